// File: rtl/wu_decode_rx_if.sv
// rtl/wu_decode_rx_if.sv - WU memory -> WU decode beat stream and decoded-record bus
// master = memory/dispatch side (testbench), slave = wu_decode_rx.
interface wu_decode_rx_if #(
  parameter int OPT_PER_INST  = 2,
  parameter int OPT_TYPE_W    = 8,
  parameter int OPT_VALUE_W   = 16,
  parameter int OP_W          = 2,
  parameter int NUM_OPT_TYPES = 8
) ();
  logic                                  wum__wud__valid;
  logic                                  wud__wum__ready;
  logic [1:0]                            wum__wud__icntl;
  logic [1:0]                            wum__wud__dcntl;
  logic [OP_W-1:0]                       wum__wud__op;
  logic [OPT_PER_INST*OPT_TYPE_W-1:0]    wum__wud__option_type;
  logic [OPT_PER_INST*OPT_VALUE_W-1:0]   wum__wud__option_value;
  logic                                  wud__dn__valid;
  logic                                  dn__wud__ready;
  logic [OP_W-1:0]                       wud__dn__op;
  logic [NUM_OPT_TYPES-1:0]              wud__dn__opt_valid;
  logic [NUM_OPT_TYPES*OPT_VALUE_W-1:0]  wud__dn__opt_value;
  logic [3:0]                            wud__dn__desc_idx;
  logic                                  wud__dn__last_desc;
  logic                                  wud__sts__proto_err;
  logic                                  wud__sts__ovf_err;

  modport master (
    output wum__wud__valid, wum__wud__icntl, wum__wud__dcntl, wum__wud__op,
           wum__wud__option_type, wum__wud__option_value, dn__wud__ready,
    input  wud__wum__ready, wud__dn__valid, wud__dn__op, wud__dn__opt_valid,
           wud__dn__opt_value, wud__dn__desc_idx, wud__dn__last_desc,
           wud__sts__proto_err, wud__sts__ovf_err
  );

  modport slave (
    input  wum__wud__valid, wum__wud__icntl, wum__wud__dcntl, wum__wud__op,
           wum__wud__option_type, wum__wud__option_value, dn__wud__ready,
    output wud__wum__ready, wud__dn__valid, wud__dn__op, wud__dn__opt_valid,
           wud__dn__opt_value, wud__dn__desc_idx, wud__dn__last_desc,
           wud__sts__proto_err, wud__sts__ovf_err
  );
endinterface

// File: rtl/wu_decode_rx.sv
// rtl/wu_decode_rx.sv - WU decode receiver: skid FIFO plus descriptor assembler
// Optional WU_DECODE_NOP_FILTER_EN: consume op==0 descriptors without emitting them.
module wu_decode_rx #(
  parameter int OPT_PER_INST  = 2,
  parameter int OPT_TYPE_W    = 8,
  parameter int OPT_VALUE_W   = 16,
  parameter int OP_W          = 2,
  parameter int NUM_OPT_TYPES = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int SKID          = 4
) (
  input logic         clk,
  input logic         reset_poweron,
  wu_decode_rx_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [1:0]                          icntl;
    logic [1:0]                          dcntl;
    logic [OP_W-1:0]                     op;
    logic [OPT_PER_INST*OPT_TYPE_W-1:0]  otype;
    logic [OPT_PER_INST*OPT_VALUE_W-1:0] oval;
  } beat_t;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  beat_t                                mem [FIFO_DEPTH];
  beat_t                                wr_beat, rd_beat;
  logic [PW-1:0]                        wr_ptr, rd_ptr;
  logic [CW-1:0]                        count, count_next;
  logic                                 push_ok, pop, ready_q;
  state_t                               state, state_next;
  logic [OP_W-1:0]                      rec_op, op_next;
  logic [NUM_OPT_TYPES-1:0]             rec_ov, ov_next;
  logic [NUM_OPT_TYPES*OPT_VALUE_W-1:0] rec_val, val_next;
  logic [3:0]                           desc_idx, idx_next;
  logic                                 last_desc, last_next;
  logic                                 in_instr, in_instr_next;
  logic                                 proto_set, proto_err, ovf_err;

  assign wr_beat = '{icntl: bus.wum__wud__icntl, dcntl: bus.wum__wud__dcntl,
                     op: bus.wum__wud__op, otype: bus.wum__wud__option_type,
                     oval: bus.wum__wud__option_value};
  assign rd_beat = mem[rd_ptr];

  // A full FIFO still accepts a beat when the same cycle pops one.
  assign push_ok    = bus.wum__wud__valid && ((count != CW'(FIFO_DEPTH)) || pop);
  assign count_next = count + CW'(push_ok) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_beat;
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ready_q   <= 1'b0;
      ovf_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count     <= count_next;
      ready_q   <= (CW'(FIFO_DEPTH) - count_next) > CW'(SKID);
      ovf_err   <= ovf_err | (bus.wum__wud__valid && !push_ok);
      proto_err <= proto_err | proto_set;
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) state <= IDLE;
    else                state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      rec_op    <= '0;
      rec_ov    <= '0;
      rec_val   <= '0;
      desc_idx  <= '0;
      last_desc <= 1'b0;
      in_instr  <= 1'b0;
    end else begin
      rec_op    <= op_next;
      rec_ov    <= ov_next;
      rec_val   <= val_next;
      desc_idx  <= idx_next;
      last_desc <= last_next;
      in_instr  <= in_instr_next;
    end
  end

  always_comb begin
    state_next    = state;
    op_next       = rec_op;
    ov_next       = rec_ov;
    val_next      = rec_val;
    idx_next      = desc_idx;
    last_next     = last_desc;
    in_instr_next = in_instr;
    proto_set     = 1'b0;
    pop           = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (count != '0) begin
          pop = 1'b1;
          if (state == IDLE && !rd_beat.dcntl[0]) begin
            proto_set = 1'b1;
          end else begin
            // dcntl bit0 marks SOM/SOM_EOM; in ACCUM it abandons the partial record.
            if (rd_beat.dcntl[0]) begin
              if (state == ACCUM) proto_set = 1'b1;
              ov_next = '0;
              op_next = rd_beat.op;
              if (rd_beat.icntl[0]) begin
                if (in_instr) proto_set = 1'b1;
                idx_next      = '0;
                in_instr_next = 1'b1;
              end
            end
            for (int s = 0; s < OPT_PER_INST; s++) begin
              if (rd_beat.otype[s*OPT_TYPE_W +: OPT_TYPE_W] >= OPT_TYPE_W'(NUM_OPT_TYPES))
                proto_set = 1'b1;
              for (int e = 1; e < NUM_OPT_TYPES; e++) begin
                if (rd_beat.otype[s*OPT_TYPE_W +: OPT_TYPE_W] == OPT_TYPE_W'(e)) begin
                  ov_next[e] = 1'b1;
                  val_next[e*OPT_VALUE_W +: OPT_VALUE_W] = rd_beat.oval[s*OPT_VALUE_W +: OPT_VALUE_W];
                end
              end
            end
            if (rd_beat.dcntl[1]) begin
              last_next = rd_beat.icntl[1];
`ifdef WU_DECODE_NOP_FILTER_EN
              if (op_next == '0) begin
                state_next = IDLE;
                if (rd_beat.icntl[1]) in_instr_next = 1'b0;
              end else begin
                state_next = EMIT;
              end
`else
              state_next = EMIT;
`endif
            end else begin
              state_next = ACCUM;
            end
          end
        end
      end
      EMIT: begin
        if (bus.dn__wud__ready) begin
          idx_next   = desc_idx + 4'd1;
          state_next = IDLE;
          if (last_desc) in_instr_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.wud__wum__ready     = ready_q;
  assign bus.wud__dn__valid      = (state == EMIT);
  assign bus.wud__dn__op         = rec_op;
  assign bus.wud__dn__opt_valid  = rec_ov;
  assign bus.wud__dn__opt_value  = rec_val;
  assign bus.wud__dn__desc_idx   = desc_idx;
  assign bus.wud__dn__last_desc  = last_desc;
  assign bus.wud__sts__proto_err = proto_err;
  assign bus.wud__sts__ovf_err   = ovf_err;
endmodule

// File: tb/tb_wu_decode_rx.sv
// tb/tb_wu_decode_rx.sv - directed self-checking bench for wu_decode_rx
// Honours WU_DECODE_NOP_FILTER_EN for the NOP descriptor expectations.
module tb_wu_decode_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wu_decode_rx_if bus ();
  wu_decode_rx dut (.clk(clk), .reset_poweron(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ic, input logic [1:0] dc, input logic [1:0] op,
                      input logic [7:0] t0, input logic [15:0] v0,
                      input logic [7:0] t1, input logic [15:0] v1);
    bus.wum__wud__valid        = 1'b1;
    bus.wum__wud__icntl        = ic;
    bus.wum__wud__dcntl        = dc;
    bus.wum__wud__op           = op;
    bus.wum__wud__option_type  = {t1, t0};
    bus.wum__wud__option_value = {v1, v0};
    tick();
    bus.wum__wud__valid = 1'b0;
  endtask

  function automatic logic [15:0] optval(input int t);
    return bus.wud__dn__opt_value[t*16 +: 16];
  endfunction

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.wud__dn__valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 64'(bus.wud__dn__valid), 64'd1);
  endtask

  task automatic rec(input string tag, input logic [1:0] op, input logic [7:0] ov,
                     input logic [3:0] idx, input logic last);
    chk({tag, "_op"},   64'(bus.wud__dn__op),        64'(op));
    chk({tag, "_ov"},   64'(bus.wud__dn__opt_valid), 64'(ov));
    chk({tag, "_idx"},  64'(bus.wud__dn__desc_idx),  64'(idx));
    chk({tag, "_last"}, 64'(bus.wud__dn__last_desc), 64'(last));
  endtask

  task automatic accept();
    bus.dn__wud__ready = 1'b1;
    tick();
    bus.dn__wud__ready = 1'b0;
  endtask

  initial begin
    bus.wum__wud__valid        = 1'b0;
    bus.wum__wud__icntl        = '0;
    bus.wum__wud__dcntl        = '0;
    bus.wum__wud__op           = '0;
    bus.wum__wud__option_type  = '0;
    bus.wum__wud__option_value = '0;
    bus.dn__wud__ready         = 1'b0;

    // reset with valid toggling
    for (int i = 0; i < 5; i++) begin
      bus.wum__wud__valid = ~bus.wum__wud__valid;
      tick();
    end
    bus.wum__wud__valid = 1'b0;
    chk("rst_ready", 64'(bus.wud__wum__ready), 64'd0);
    chk("rst_dn_valid", 64'(bus.wud__dn__valid), 64'd0);
    rec("rst", 2'd0, 8'h00, 4'd0, 1'b0);
    chk("rst_proto", 64'(bus.wud__sts__proto_err), 64'd0);
    chk("rst_ovf", 64'(bus.wud__sts__ovf_err), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", 64'(bus.wud__wum__ready), 64'd1);
    chk("rel_dn_valid", 64'(bus.wud__dn__valid), 64'd0);

    // single-beat descriptor latency
    send(2'b11, 2'b11, 2'd1, 8'd1, 16'h0010, 8'd3, 16'h00AB);
    chk("lat_n1", 64'(bus.wud__dn__valid), 64'd0);
    tick();
    chk("lat_n2", 64'(bus.wud__dn__valid), 64'd1);
    rec("single", 2'd1, 8'h0A, 4'd0, 1'b1);
    chk("single_v1", 64'(optval(1)), 64'h0010);
    chk("single_v3", 64'(optval(3)), 64'h00AB);
    accept();
    chk("single_done", 64'(bus.wud__dn__valid), 64'd0);

    // two 3-beat descriptors plus one single-beat instruction, dn_ready low
    send(2'b01, 2'b01, 2'd2, 8'd2, 16'h1111, 8'd0, 16'h0000);
    send(2'b00, 2'b00, 2'd2, 8'd4, 16'h4444, 8'd0, 16'h0000);
    send(2'b00, 2'b10, 2'd2, 8'd2, 16'h3333, 8'd5, 16'h5555);
    send(2'b00, 2'b01, 2'd1, 8'd1, 16'h0101, 8'd0, 16'h0000);
    send(2'b00, 2'b00, 2'd1, 8'd7, 16'h0707, 8'd0, 16'h0000);
    send(2'b10, 2'b10, 2'd1, 8'd0, 16'h0000, 8'd0, 16'h0000);
    chk("bp_ready_3used", 64'(bus.wud__wum__ready), 64'd1);
    send(2'b11, 2'b11, 2'd3, 8'd6, 16'h0606, 8'd0, 16'h0000);
    chk("bp_ready_4used", 64'(bus.wud__wum__ready), 64'd0);
    repeat (20) tick();
    chk("bp_ready_hold", 64'(bus.wud__wum__ready), 64'd0);
    chk("bp_ovf", 64'(bus.wud__sts__ovf_err), 64'd0);
    wait_valid("d0");
    rec("d0", 2'd2, 8'h34, 4'd0, 1'b0);
    chk("d0_v2", 64'(optval(2)), 64'h3333);
    chk("d0_v4", 64'(optval(4)), 64'h4444);
    chk("d0_v5", 64'(optval(5)), 64'h5555);
    accept();
    wait_valid("d1");
    rec("d1", 2'd1, 8'h82, 4'd1, 1'b1);
    chk("d1_v1", 64'(optval(1)), 64'h0101);
    chk("d1_v7", 64'(optval(7)), 64'h0707);
    accept();
    wait_valid("d2");
    rec("d2", 2'd3, 8'h40, 4'd0, 1'b1);
    chk("d2_v6", 64'(optval(6)), 64'h0606);
    accept();
    tick();
    chk("bp_ready_back", 64'(bus.wud__wum__ready), 64'd1);
    chk("bp_proto", 64'(bus.wud__sts__proto_err), 64'd0);

    // MOM beat in IDLE is a protocol error; next descriptor still decodes
    send(2'b00, 2'b00, 2'd1, 8'd1, 16'h0001, 8'd0, 16'h0000);
    tick();
    tick();
    chk("pe_proto", 64'(bus.wud__sts__proto_err), 64'd1);
    chk("pe_dropped", 64'(bus.wud__dn__valid), 64'd0);
    send(2'b11, 2'b11, 2'd2, 8'd5, 16'hBEEF, 8'd8, 16'h9999);
    wait_valid("pe_rec");
    rec("pe_rec", 2'd2, 8'h20, 4'd0, 1'b1);
    chk("pe_v5", 64'(optval(5)), 64'hBEEF);
    accept();
    chk("pe_sticky", 64'(bus.wud__sts__proto_err), 64'd1);

    // overflow: 12 back-to-back beats ignoring ready
    for (int i = 1; i <= 12; i++) send(2'b11, 2'b11, 2'd1, 8'd1, 16'(i), 8'd0, 16'h0000);
    chk("ovf_set", 64'(bus.wud__sts__ovf_err), 64'd1);
    for (int i = 1; i <= 9; i++) begin
      wait_valid($sformatf("ovf_b%0d", i));
      chk($sformatf("ovf_b%0d_v1", i), 64'(optval(1)), 64'(i));
      chk($sformatf("ovf_b%0d_ov", i), 64'(bus.wud__dn__opt_valid), 64'h02);
      accept();
    end
    repeat (8) tick();
    chk("ovf_drained", 64'(bus.wud__dn__valid), 64'd0);

    // NOP descriptor followed by op 2 in the same instruction
    send(2'b01, 2'b11, 2'd0, 8'd1, 16'h0A0A, 8'd0, 16'h0000);
    send(2'b10, 2'b11, 2'd2, 8'd3, 16'h0303, 8'd0, 16'h0000);
`ifdef WU_DECODE_NOP_FILTER_EN
    wait_valid("nop_op2");
    rec("nop_op2", 2'd2, 8'h08, 4'd0, 1'b1);
    chk("nop_op2_v3", 64'(optval(3)), 64'h0303);
    accept();
`else
    wait_valid("nop_op0");
    rec("nop_op0", 2'd0, 8'h02, 4'd0, 1'b0);
    accept();
    wait_valid("nop_op2");
    rec("nop_op2", 2'd2, 8'h08, 4'd1, 1'b1);
    chk("nop_op2_v3", 64'(optval(3)), 64'h0303);
    accept();
`endif
    repeat (5) tick();
    chk("nop_end", 64'(bus.wud__dn__valid), 64'd0);
    chk("end_ovf_sticky", 64'(bus.wud__sts__ovf_err), 64'd1);
    chk("end_proto_sticky", 64'(bus.wud__sts__proto_err), 64'd1);

    // asynchronous reset mid-record discards the partial descriptor
    send(2'b01, 2'b01, 2'd1, 8'd4, 16'h4040, 8'd0, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(bus.wud__wum__ready), 64'd0);
    chk("arst_proto", 64'(bus.wud__sts__proto_err), 64'd0);
    chk("arst_ovf", 64'(bus.wud__sts__ovf_err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(2'b11, 2'b11, 2'd1, 8'd2, 16'h0022, 8'd0, 16'h0000);
    wait_valid("arst_rec");
    rec("arst_rec", 2'd1, 8'h04, 4'd0, 1'b1);
    chk("arst_v2", 64'(optval(2)), 64'h0022);
    accept();
    chk("arst_proto_after", 64'(bus.wud__sts__proto_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
